// File: rtl/emissions_alert_controller.sv
// Debounces the emissions warning/critical flags and escalates them to the LED, buzzer, limp-mode request and a critical-event count.
// Outputs are registered from the next state (one edge after q_lvl); there is no backpressure, and inputs are sampled every cycle.
module emissions_alert_controller #(
  parameter int DEBOUNCE    = 4,
  parameter int LIMP_CYCLES = 16,
  parameter int BLINK_HALF  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       warning,
  input  logic       critical,
  input  logic       ack,
  output logic       alert_led,
  output logic       buzzer,
  output logic       limp_mode,
  output logic [7:0] event_count,
  output logic [1:0] state_out
);

  localparam logic [7:0]  DEB_MAX   = 8'(DEBOUNCE);
  localparam logic [15:0] LIMP_MAX  = 16'(LIMP_CYCLES);
  localparam logic [7:0]  BLINK_MAX = 8'(BLINK_HALF);

  typedef enum logic [1:0] {
    ST_OK   = 2'd0,
    ST_WARN = 2'd1,
    ST_CRIT = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t      state, state_n;
  logic [1:0]  lvl, cand, q_lvl;
  logic [7:0]  deb_cnt, deb_cnt_n;
  logic [15:0] limp_cnt, limp_cnt_n;
  logic [7:0]  blink_cnt;

  always_comb begin
    lvl = 2'd0;
    if (critical)     lvl = 2'd2;
    else if (warning) lvl = 2'd1;
  end

  // A changed level restarts the stability count at 1, so DEBOUNCE=1 qualifies on the same edge.
  always_comb begin
    deb_cnt_n = deb_cnt;
    if (lvl != cand)            deb_cnt_n = 8'd1;
    else if (deb_cnt != DEB_MAX) deb_cnt_n = deb_cnt + 8'd1;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_OK: begin
        if (q_lvl == 2'd2)      state_n = ST_CRIT;
        else if (q_lvl == 2'd1) state_n = ST_WARN;
      end
      ST_WARN: begin
        if (q_lvl == 2'd2)      state_n = ST_CRIT;
        else if (q_lvl == 2'd0) state_n = ST_OK;
      end
      ST_CRIT: begin
        if (q_lvl != 2'd2)      state_n = ST_HOLD;
      end
      ST_HOLD: begin
        if (q_lvl == 2'd2)      state_n = ST_CRIT;
        else if (ack)           state_n = (q_lvl == 2'd1) ? ST_WARN : ST_OK;
      end
      default:                  state_n = ST_OK;
    endcase
  end

  always_comb begin
    limp_cnt_n = 16'd0;
    if (state_n == ST_CRIT) begin
      if (state != ST_CRIT)           limp_cnt_n = 16'd1;
      else if (limp_cnt != LIMP_MAX)  limp_cnt_n = limp_cnt + 16'd1;
      else                            limp_cnt_n = limp_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cand        <= 2'd0;
      q_lvl       <= 2'd0;
      deb_cnt     <= 8'd0;
      state       <= ST_OK;
      limp_cnt    <= 16'd0;
      blink_cnt   <= 8'd0;
      alert_led   <= 1'b0;
      buzzer      <= 1'b0;
      limp_mode   <= 1'b0;
      event_count <= 8'd0;
    end else begin
      cand     <= lvl;
      deb_cnt  <= deb_cnt_n;
      if (deb_cnt_n == DEB_MAX) q_lvl <= lvl;

      state    <= state_n;
      buzzer   <= (state_n == ST_CRIT);
      limp_cnt <= limp_cnt_n;

      if (state_n == ST_CRIT && state != ST_CRIT && event_count != 8'hFF)
        event_count <= event_count + 8'd1;

      // Limp is sticky across CRIT/HOLD re-entries; only an acknowledged exit from HOLD releases it.
      if (state_n == ST_CRIT && limp_cnt_n == LIMP_MAX)
        limp_mode <= 1'b1;
      else if (state == ST_HOLD && (state_n == ST_OK || state_n == ST_WARN))
        limp_mode <= 1'b0;

      if (state_n == ST_WARN) begin
        if (state != ST_WARN) begin
          blink_cnt <= 8'd1;
          alert_led <= 1'b1;
        end else if (blink_cnt == BLINK_MAX) begin
          blink_cnt <= 8'd1;
          alert_led <= ~alert_led;
        end else begin
          blink_cnt <= blink_cnt + 8'd1;
        end
      end else begin
        blink_cnt <= 8'd0;
        alert_led <= (state_n == ST_CRIT) || (state_n == ST_HOLD);
      end
    end
  end

  assign state_out = state;

endmodule

// File: tb/tb_emissions_alert_controller.sv
// Randomized and directed stimulus for emissions_alert_controller, checked every cycle against a behavioural model.
module tb_emissions_alert_controller;

  localparam int DEB  = 4;
  localparam int LIMP = 16;
  localparam int BH   = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       warning = 1'b0;
  logic       critical = 1'b0;
  logic       ack = 1'b0;
  logic       alert_led, buzzer, limp_mode;
  logic [7:0] event_count;
  logic [1:0] state_out;

  int total = 0;
  int bad   = 0;

  // Reference model state: states are 0=OK 1=WARN 2=CRIT 3=HOLD
  int m_state = 0, m_q = 0, m_ev = 0, m_limp = 0, m_crit_run = 0, m_warn_age = 0;
  int hist[$];

  emissions_alert_controller #(.DEBOUNCE(DEB), .LIMP_CYCLES(LIMP), .BLINK_HALF(BH)) dut (
    .clk(clk), .reset(reset), .warning(warning), .critical(critical), .ack(ack),
    .alert_led(alert_led), .buzzer(buzzer), .limp_mode(limp_mode),
    .event_count(event_count), .state_out(state_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    int lvl, prev, nxt;
    bit same;
    if (reset) begin
      m_state = 0; m_q = 0; m_ev = 0; m_limp = 0; m_crit_run = 0; m_warn_age = 0;
      hist.delete();
      return;
    end
    lvl  = critical ? 2 : (warning ? 1 : 0);
    prev = m_state;
    nxt  = prev;
    case (prev)
      0: if (m_q != 0) nxt = m_q;
      1: if (m_q != 1) nxt = m_q;
      2: if (m_q != 2) nxt = 3;
      default: if (m_q == 2 || ack) nxt = m_q;
    endcase
    if (nxt == 2 && prev != 2 && m_ev < 255) m_ev++;
    m_crit_run = (nxt == 2) ? ((prev == 2) ? m_crit_run + 1 : 1) : 0;
    if (nxt == 2 && m_crit_run >= LIMP) m_limp = 1;
    if (prev == 3 && nxt < 2) m_limp = 0;
    m_warn_age = (nxt == 1 && prev == 1) ? m_warn_age + 1 : 0;
    m_state = nxt;
    // Qualified level is whatever the last DEB samples since reset all agree on
    hist.push_back(lvl);
    if (hist.size() > DEB) void'(hist.pop_front());
    if (hist.size() == DEB) begin
      same = 1'b1;
      foreach (hist[i]) if (hist[i] != lvl) same = 1'b0;
      if (same) m_q = lvl;
    end
  endtask

  function automatic int exp_led();
    if (m_state == 0) return 0;
    if (m_state == 1) return ((m_warn_age / BH) % 2 == 0) ? 1 : 0;
    return 1;
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("state",  int'(state_out),   m_state);
    chk("led",    int'(alert_led),   exp_led());
    chk("buzzer", int'(buzzer),      (m_state == 2) ? 1 : 0);
    chk("limp",   int'(limp_mode),   m_limp);
    chk("events", int'(event_count), m_ev);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    run(2);
    chk("rst_state", int'(state_out), 0);
    chk("rst_events", int'(event_count), 0);

    // Warning qualified after DEB edges, WARN one edge later, then blinking
    reset = 1'b0; warning = 1'b1;
    run(5);
    chk("t1_warn", int'(state_out), 1);
    chk("t1_led_on", int'(alert_led), 1);
    run(4);
    chk("t1_led_off", int'(alert_led), 0);
    run(12);

    // Short critical pulse must be rejected
    warning = 1'b0;
    run(8);
    critical = 1'b1; run(3);
    critical = 1'b0; run(6);
    chk("t2_glitch_state", int'(state_out), 0);
    chk("t2_glitch_events", int'(event_count), 0);

    // CRIT, latch in HOLD, release only on ack
    critical = 1'b1; run(10);
    chk("t3_buzzer", int'(buzzer), 1);
    chk("t3_events", int'(event_count), 1);
    critical = 1'b0; run(28);
    chk("t3_hold", int'(state_out), 3);
    ack = 1'b1; run(1);
    chk("t3_ack_ok", int'(state_out), 0);
    chk("t3_ack_led", int'(alert_led), 0);
    ack = 1'b0;

    // Sustained critical sets limp; acked exit to WARN clears it
    critical = 1'b1; run(30);
    chk("t4_limp", int'(limp_mode), 1);
    critical = 1'b0; warning = 1'b1; run(10);
    chk("t4_hold_limp", int'(limp_mode), 1);
    ack = 1'b1; run(1);
    chk("t4_warn", int'(state_out), 1);
    chk("t4_limp_clr", int'(limp_mode), 0);
    ack = 1'b0; warning = 1'b0; run(6);

    // Re-qualified critical in HOLD beats ack
    critical = 1'b1; run(6);
    critical = 1'b0; run(6);
    critical = 1'b1; run(4);
    ack = 1'b1; run(1);
    chk("t5_recrit", int'(state_out), 2);
    ack = 1'b0;

    // Saturate the event counter
    for (int k = 0; k < 260; k++) begin
      critical = 1'b0; run(6);
      critical = 1'b1; run(6);
    end
    chk("t5_sat", int'(event_count), 255);

    // Reset from CRIT with limp set
    run(20);
    chk("t6_limp", int'(limp_mode), 1);
    reset = 1'b1; run(1);
    chk("t6_rst_state", int'(state_out), 0);
    chk("t6_rst_limp", int'(limp_mode), 0);
    chk("t6_rst_events", int'(event_count), 0);
    reset = 1'b0; critical = 1'b0; run(10);
    chk("t6_stay_ok", int'(state_out), 0);

    // Random segments of held flags with assorted ack behaviour and occasional reset
    for (int s = 0; s < 300; s++) begin
      int len, kind, ackmode;
      len     = $urandom_range(1, 20);
      kind    = $urandom_range(0, 3);
      ackmode = $urandom_range(0, 2);
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1; run(1); reset = 1'b0;
      end
      warning  = (kind == 1 || kind == 3);
      critical = (kind >= 2);
      for (int c = 0; c < len; c++) begin
        ack = (ackmode == 0) ? 1'b0 : (ackmode == 1) ? 1'b1 : ($urandom_range(0, 3) == 0);
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
